// File: rtl/json_scan_ctrl_if.sv
// Byte-stream and result channels of the JSON structural scanner.
// res_max_depth is present only when JSON_SCAN_MAX_DEPTH_STAT_EN is defined.
interface json_scan_ctrl_if #(
  parameter int MAX_DEPTH = 16,
  parameter int POS_W     = 32
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_err;
  logic [2:0]       res_kind;
  logic [POS_W-1:0] res_pos;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
  logic [DEPTH_W-1:0] res_max_depth;
`endif

  // Byte producer / result consumer side.
  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_err, res_kind, res_pos
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
    , input res_max_depth
`endif
  );

  // Scanner side.
  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_err, res_kind, res_pos
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
    , output res_max_depth
`endif
  );
endinterface

// File: rtl/json_scan_ctrl.sv
// Streaming structural JSON scanner: one byte per cycle, one OK/error result per frame.
// Optional peak-depth statistic on res_max_depth with JSON_SCAN_MAX_DEPTH_STAT_EN.
module json_scan_ctrl #(
  parameter int MAX_DEPTH = 16,
  parameter int POS_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  json_scan_ctrl_if.slave bus
);
  localparam int            DW         = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(MAX_DEPTH);

  typedef enum logic [3:0] {
    S_VALUE, S_VALUE_OR_CLOSE, S_KEY, S_KEY2, S_STR, S_ESC,
    S_UHEX, S_LIT, S_NUM, S_COLON, S_AFTER
  } state_e;

  typedef enum logic [2:0] {
    K_OK = 3'd0, K_EOF = 3'd1, K_UNEXPECTED = 3'd2,
    K_DEPTH = 3'd3, K_TRAILING = 3'd4, K_ESCAPE = 3'd5
  } kind_e;

  typedef enum logic [1:0] {LIT_TRUE, LIT_FALSE, LIT_NULL} lit_e;

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= "a") && (c <= "f")) || ((c >= "A") && (c <= "F"));
  endfunction

  function automatic logic is_num(input logic [7:0] c);
    return is_digit(c) || (c == "+") || (c == "-") || (c == ".") || (c == "e") || (c == "E");
  endfunction

  function automatic logic is_simple_esc(input logic [7:0] c);
    return (c == 8'h22) || (c == 8'h5C) || (c == "/") || (c == "b") ||
           (c == "f") || (c == "n") || (c == "r") || (c == "t");
  endfunction

  // Character expected at index idx of the literal being matched.
  function automatic logic [7:0] lit_char(input lit_e sel, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (sel)
      LIT_TRUE: case (idx)
        3'd0: c = "t";  3'd1: c = "r";  3'd2: c = "u";  3'd3: c = "e";
        default: c = 8'h00;
      endcase
      LIT_FALSE: case (idx)
        3'd0: c = "f";  3'd1: c = "a";  3'd2: c = "l";  3'd3: c = "s";  3'd4: c = "e";
        default: c = 8'h00;
      endcase
      default: case (idx)
        3'd0: c = "n";  3'd1: c = "u";  3'd2: c = "l";  3'd3: c = "l";
        default: c = 8'h00;
      endcase
    endcase
    return c;
  endfunction

  function automatic logic [2:0] lit_last(input lit_e sel);
    return (sel == LIT_FALSE) ? 3'd4 : 3'd3;
  endfunction

  state_e               state_q, state_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic                 key_q, key_d;
  lit_e                 lit_sel_q, lit_sel_d;
  logic [2:0]           lit_idx_q, lit_idx_d;
  logic [1:0]           hex_cnt_q, hex_cnt_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 err_q, err_d;
  kind_e                err_kind_q, err_kind_d;
  logic [POS_W-1:0]     err_pos_q, err_pos_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_err_q, res_err_d;
  kind_e                res_kind_q, res_kind_d;
  logic [POS_W-1:0]     res_pos_q, res_pos_d;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
  logic [DW-1:0]        peak_q, peak_d;
  logic [DW-1:0]        res_peak_q, res_peak_d;
`endif

  state_e           eff;
  logic [7:0]       b;
  logic             accept;
  logic             byte_err;
  kind_e            byte_kind;
  logic             push, push_obj, pop;
  logic             frame_ok;
  logic [POS_W-1:0] pos_inc;

  assign b        = bus.in_data;
  assign accept   = bus.in_valid && !res_valid_q;
  assign pos_inc  = (&pos_q) ? pos_q : pos_q + 1'b1;

  assign bus.in_ready  = !res_valid_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_kind  = res_kind_q;
  assign bus.res_pos   = res_pos_q;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
  assign bus.res_max_depth = res_peak_q;
`endif

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    stack_d     = stack_q;
    key_d       = key_q;
    lit_sel_d   = lit_sel_q;
    lit_idx_d   = lit_idx_q;
    hex_cnt_d   = hex_cnt_q;
    pos_d       = pos_q;
    err_d       = err_q;
    err_kind_d  = err_kind_q;
    err_pos_d   = err_pos_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_kind_d  = res_kind_q;
    res_pos_d   = res_pos_q;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
    peak_d      = peak_q;
    res_peak_d  = res_peak_q;
`endif
    eff       = state_q;
    byte_err  = 1'b0;
    byte_kind = K_UNEXPECTED;
    push      = 1'b0;
    push_obj  = 1'b0;
    pop       = 1'b0;
    frame_ok  = 1'b0;

    if (res_valid_q) begin
      // Result handshake also rearms the scanner for the next frame.
      if (bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = S_VALUE;
        depth_d     = '0;
        stack_d     = '0;
        key_d       = 1'b0;
        lit_idx_d   = '0;
        hex_cnt_d   = '0;
        pos_d       = '0;
        err_d       = 1'b0;
        err_kind_d  = K_OK;
        err_pos_d   = '0;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
        peak_d      = '0;
`endif
      end
    end else if (accept) begin
      pos_d = pos_inc;
      if (!err_q) begin
        // A byte that cannot extend a number is handled as if the number had already ended.
        if (state_q == S_NUM && !is_num(b)) eff = S_AFTER;
        state_d = eff;
        case (eff)
          S_VALUE, S_VALUE_OR_CLOSE: begin
            if (eff == S_VALUE_OR_CLOSE && b == 8'h5D) pop = 1'b1;
            else if (b == 8'h7B) begin push = 1'b1; push_obj = 1'b1; state_d = S_KEY; end
            else if (b == 8'h5B) begin push = 1'b1; state_d = S_VALUE_OR_CLOSE; end
            else if (b == 8'h22) begin key_d = 1'b0; state_d = S_STR; end
            else if (b == "t") begin lit_sel_d = LIT_TRUE;  lit_idx_d = 3'd1; state_d = S_LIT; end
            else if (b == "f") begin lit_sel_d = LIT_FALSE; lit_idx_d = 3'd1; state_d = S_LIT; end
            else if (b == "n") begin lit_sel_d = LIT_NULL;  lit_idx_d = 3'd1; state_d = S_LIT; end
            else if (b == "-" || is_digit(b)) state_d = S_NUM;
            else if (!is_ws(b)) byte_err = 1'b1;
          end
          S_KEY, S_KEY2: begin
            if (b == 8'h22) begin key_d = 1'b1; state_d = S_STR; end
            else if (eff == S_KEY && b == 8'h7D) pop = 1'b1;
            else if (!is_ws(b)) byte_err = 1'b1;
          end
          S_STR: begin
            if (b == 8'h5C) state_d = S_ESC;
            else if (b == 8'h22) state_d = key_q ? S_COLON : S_AFTER;
            else if (b < 8'h20) byte_err = 1'b1;
          end
          S_ESC: begin
            if (b == "u") begin hex_cnt_d = 2'd0; state_d = S_UHEX; end
            else if (is_simple_esc(b)) state_d = S_STR;
            else begin byte_err = 1'b1; byte_kind = K_ESCAPE; end
          end
          S_UHEX: begin
            if (!is_hex(b)) begin byte_err = 1'b1; byte_kind = K_ESCAPE; end
            else if (hex_cnt_q == 2'd3) state_d = S_STR;
            else hex_cnt_d = hex_cnt_q + 2'd1;
          end
          S_LIT: begin
            if (b != lit_char(lit_sel_q, lit_idx_q)) byte_err = 1'b1;
            else if (lit_idx_q == lit_last(lit_sel_q)) state_d = S_AFTER;
            else lit_idx_d = lit_idx_q + 3'd1;
          end
          S_NUM: begin
            state_d = S_NUM;
          end
          S_COLON: begin
            if (b == ":") state_d = S_VALUE;
            else if (!is_ws(b)) byte_err = 1'b1;
          end
          default: begin
            // stack_q[0] is the innermost container: 1 = object, 0 = array.
            if (is_ws(b)) state_d = S_AFTER;
            else if (depth_q == '0) begin byte_err = 1'b1; byte_kind = K_TRAILING; end
            else if (b == ",") state_d = stack_q[0] ? S_KEY2 : S_VALUE;
            else if ((b == 8'h7D && stack_q[0]) || (b == 8'h5D && !stack_q[0])) pop = 1'b1;
            else byte_err = 1'b1;
          end
        endcase

        if (push) begin
          if (depth_q == DEPTH_FULL) begin
            byte_err  = 1'b1;
            byte_kind = K_DEPTH;
          end else begin
            depth_d = depth_q + 1'b1;
            stack_d = (stack_q << 1) | MAX_DEPTH'(push_obj);
          end
        end
        if (pop) begin
          depth_d = depth_q - 1'b1;
          stack_d = stack_q >> 1;
          state_d = S_AFTER;
        end
        if (byte_err) begin
          err_d      = 1'b1;
          err_kind_d = byte_kind;
          err_pos_d  = pos_q;
        end
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
        if (!byte_err && depth_d > peak_q) peak_d = depth_d;
`endif
      end

      if (bus.in_last) begin
        frame_ok    = !err_d && (depth_d == '0) && (state_d == S_AFTER || state_d == S_NUM);
        res_valid_d = 1'b1;
        res_err_d   = !frame_ok;
        res_kind_d  = err_d ? err_kind_d : (frame_ok ? K_OK : K_EOF);
        res_pos_d   = err_d ? err_pos_d : pos_inc;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
        res_peak_d  = peak_d;
`endif
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the nesting stack is a plain register, so it is reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_VALUE;
      depth_q     <= '0;
      stack_q     <= '0;
      key_q       <= 1'b0;
      lit_sel_q   <= LIT_TRUE;
      lit_idx_q   <= '0;
      hex_cnt_q   <= '0;
      pos_q       <= '0;
      err_q       <= 1'b0;
      err_kind_q  <= K_OK;
      err_pos_q   <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_kind_q  <= K_OK;
      res_pos_q   <= '0;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
      peak_q      <= '0;
      res_peak_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      stack_q     <= stack_d;
      key_q       <= key_d;
      lit_sel_q   <= lit_sel_d;
      lit_idx_q   <= lit_idx_d;
      hex_cnt_q   <= hex_cnt_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
      err_kind_q  <= err_kind_d;
      err_pos_q   <= err_pos_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_kind_q  <= res_kind_d;
      res_pos_q   <= res_pos_d;
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
      peak_q      <= peak_d;
      res_peak_q  <= res_peak_d;
`endif
    end
  end

endmodule

// File: tb/tb_json_scan_ctrl.sv
// Self-checking bench for json_scan_ctrl: directed frames, then random frames scored
// against a token-level reference parser.
module tb_json_scan_ctrl;
  localparam int MAX_DEPTH = 16;
  localparam int POS_W     = 32;
  localparam int R_OK = 0, R_EOF = 1, R_UNEXP = 2, R_DEPTH = 3, R_TRAIL = 4, R_ESC = 5;
  localparam int W_VAL = 0, W_VOC = 1, W_KEY = 2, W_KEY2 = 3, W_COLON = 4, W_AFTER = 5;

  typedef logic [7:0] u8_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  json_scan_ctrl_if #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) bus ();

  json_scan_ctrl #(.MAX_DEPTH(MAX_DEPTH), .POS_W(POS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  string frags [0:23] = '{
    "{", "}", "[", "]", ",", ":", " ", "\"k\"", "\"k\":", "1", "-2.5e+3", "true",
    "false", "null", "nul", "\"a\\\"b\"", "\"\\u12aF\"", "\"\\u1G\"", "\"\\x\"",
    "{\"k\":[1,{}]}", "[[],[true ]]", "x", "\n\t", "[[[[["
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void str2q(input string s, output u8_t q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(u8_t'(s[i]));
  endfunction

  function automatic bit ws(input u8_t c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
  endfunction

  function automatic bit digit(input u8_t c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  function automatic bit hexc(input u8_t c);
    return digit(c) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
  endfunction

  function automatic bit numc(input u8_t c);
    return digit(c) || c == 8'h2B || c == 8'h2D || c == 8'h2E || c == 8'h65 || c == 8'h45;
  endfunction

  // Consumes a whole string token starting at its opening quote.
  function automatic void scan_str(input u8_t f[$], inout int i, inout int kind,
                                   inout int pos, inout bit part);
    int n = f.size();
    i++;
    while (kind < 0 && !part) begin
      if (i == n) begin part = 1; break; end
      if (f[i] == 8'h22) begin i++; break; end
      if (f[i] == 8'h5C) begin
        i++;
        if (i == n) begin part = 1; break; end
        if (f[i] == 8'h75) begin
          i++;
          for (int k = 0; k < 4 && kind < 0 && !part; k++) begin
            if (i == n) part = 1;
            else if (!hexc(f[i])) begin kind = R_ESC; pos = i; end
            else i++;
          end
        end else if (f[i] == 8'h22 || f[i] == 8'h5C || f[i] == 8'h2F || f[i] == 8'h62 ||
                     f[i] == 8'h66 || f[i] == 8'h6E || f[i] == 8'h72 || f[i] == 8'h74) begin
          i++;
        end else begin
          kind = R_ESC; pos = i;
        end
      end else if (f[i] < 8'h20) begin
        kind = R_UNEXP; pos = i;
      end else begin
        i++;
      end
    end
  endfunction

  // Token-at-a-time reference parser with a queue of pending closing brackets.
  function automatic void ref_scan(input u8_t f[$], output int kind, output int pos,
                                   output int peak);
    u8_t   stk[$];
    int    n    = f.size();
    int    i    = 0;
    int    want = W_VAL;
    bit    part = 0;
    string w;
    u8_t   c;
    kind = -1; pos = 0; peak = 0;
    while (i < n && kind < 0 && !part) begin
      c = f[i];
      if (ws(c)) begin i++; continue; end
      case (want)
        W_VAL, W_VOC: begin
          if (want == W_VOC && c == 8'h5D) begin
            void'(stk.pop_back()); want = W_AFTER; i++;
          end else if (c == 8'h7B || c == 8'h5B) begin
            if (stk.size() == MAX_DEPTH) begin kind = R_DEPTH; pos = i; end
            else begin
              stk.push_back(c == 8'h7B ? 8'h7D : 8'h5D);
              if (stk.size() > peak) peak = stk.size();
              want = (c == 8'h7B) ? W_KEY : W_VOC;
              i++;
            end
          end else if (c == 8'h22) begin
            scan_str(f, i, kind, pos, part); want = W_AFTER;
          end else if (c == 8'h74 || c == 8'h66 || c == 8'h6E) begin
            if (c == 8'h74) w = "true";
            else if (c == 8'h66) w = "false";
            else w = "null";
            for (int k = 0; k < w.len() && kind < 0 && !part; k++) begin
              if (i == n) part = 1;
              else if (f[i] != u8_t'(w[k])) begin kind = R_UNEXP; pos = i; end
              else i++;
            end
            want = W_AFTER;
          end else if (c == 8'h2D || digit(c)) begin
            while (i < n && numc(f[i])) i++;
            want = W_AFTER;
          end else begin
            kind = R_UNEXP; pos = i;
          end
        end
        W_KEY, W_KEY2: begin
          if (c == 8'h22) begin scan_str(f, i, kind, pos, part); want = W_COLON; end
          else if (want == W_KEY && c == 8'h7D) begin void'(stk.pop_back()); want = W_AFTER; i++; end
          else begin kind = R_UNEXP; pos = i; end
        end
        W_COLON: begin
          if (c == 8'h3A) begin want = W_VAL; i++; end
          else begin kind = R_UNEXP; pos = i; end
        end
        default: begin
          if (stk.size() == 0) begin kind = R_TRAIL; pos = i; end
          else if (c == 8'h2C) begin want = (stk[$] == 8'h7D) ? W_KEY2 : W_VAL; i++; end
          else if (c == stk[$]) begin void'(stk.pop_back()); i++; end
          else begin kind = R_UNEXP; pos = i; end
        end
      endcase
    end
    if (kind < 0) begin
      pos  = n;
      kind = (!part && stk.size() == 0 && want == W_AFTER) ? R_OK : R_EOF;
    end
  endfunction

  // Feeds a frame, checks result timing/values/stability, then completes the handshake.
  task automatic run_frame(input string name, input u8_t f[$], input int exp_kind,
                           input int exp_pos, input int exp_peak, input int hold,
                           input bit gaps);
    int t;
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      bus.in_last  = (i == f.size() - 1);
      t = 0;
      while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
        check({name, ".in_ready_timeout"}, 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check({name, ".res_valid"}, 64'(bus.res_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      check({name, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({name, ".hold_kind"}, 64'(bus.res_kind), 64'(exp_kind));
      check({name, ".hold_pos"}, 64'(bus.res_pos), 64'(exp_pos));
      @(negedge clk);
      check({name, ".hold_valid"}, 64'(bus.res_valid), 64'd1);
    end
    check({name, ".in_ready_low"}, 64'(bus.in_ready), 64'd0);
    check({name, ".res_err"}, 64'(bus.res_err), 64'(exp_kind != R_OK));
    check({name, ".res_kind"}, 64'(bus.res_kind), 64'(exp_kind));
    check({name, ".res_pos"}, 64'(bus.res_pos), 64'(exp_pos));
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
    check({name, ".res_max_depth"}, 64'(bus.res_max_depth), 64'(exp_peak));
`endif
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, ".res_valid_clr"}, 64'(bus.res_valid), 64'd0);
    check({name, ".in_ready_back"}, 64'(bus.in_ready), 64'd1);
    if (exp_peak < 0) check({name, ".peak_model"}, 64'd0, 64'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u8_t   q[$];
    string s;
    int    mk, mp, mpk, nf;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);
    check("reset.res_valid", 64'(bus.res_valid), 64'd0);
    check("reset.res_err", 64'(bus.res_err), 64'd0);
    check("reset.res_kind", 64'(bus.res_kind), 64'd0);
    check("reset.res_pos", 64'(bus.res_pos), 64'd0);
    rst_n = 1'b1;

    str2q("{\"a\":[1,true]}", q);
    run_frame("obj_ok", q, R_OK, 14, 2, 0, 0);
    str2q("[1,2", q);
    run_frame("arr_eof", q, R_EOF, 4, 1, 0, 0);
    str2q("{\"a\" 1}", q);
    run_frame("missing_colon", q, R_UNEXP, 5, 1, 0, 0);
    str2q("\"x\\q\"", q);
    run_frame("bad_escape", q, R_ESC, 3, 0, 0, 0);
    q = {};
    for (int i = 0; i < 17; i++) q.push_back(8'h5B);
    run_frame("depth", q, R_DEPTH, 16, 16, 0, 0);
    str2q("1 2", q);
    run_frame("trailing_hold", q, R_TRAIL, 2, 0, 5, 0);
    str2q("null", q);
    run_frame("null_ok", q, R_OK, 4, 0, 0, 0);

    str2q("{\"a", q);
    foreach (q[i]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      bus.in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst.res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst.res_err", 64'(bus.res_err), 64'd0);
    check("midrst.res_kind", 64'(bus.res_kind), 64'd0);
    check("midrst.res_pos", 64'(bus.res_pos), 64'd0);
`ifdef JSON_SCAN_MAX_DEPTH_STAT_EN
    check("midrst.res_max_depth", 64'(bus.res_max_depth), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    str2q("[]", q);
    run_frame("after_abort", q, R_OK, 2, 1, 0, 0);

    for (int r = 0; r < 250; r++) begin
      s  = "";
      nf = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 8);
      for (int k = 0; k < nf; k++) s = {s, frags[$urandom_range(0, 23)]};
      str2q(s, q);
      if ($urandom_range(0, 3) == 0) q[$urandom_range(0, q.size() - 1)] = u8_t'($urandom_range(0, 255));
      ref_scan(q, mk, mp, mpk);
      run_frame($sformatf("rand%0d", r), q, mk, mp, mpk, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/json_scan_ctrl.md
Name: json_scan_ctrl

Overview:
- Streaming structural JSON scanner/controller: consumes one byte per cycle on a valid/ready stream and sequences a grammar FSM with a nesting stack.
- Returns one result per frame: OK, or error kind plus 0-based byte position.
- Hardware front-end for the decoder flow: frames the OK/error and error-position contract of the software decoder ahead of the value-building datapath.

Parameters:
- MAX_DEPTH, 16, maximum object/array nesting depth (1..64).
- POS_W, 32, width of byte-position counter and res_pos.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_data  in  8  byte.
- in_last  in  1  final byte of frame; every frame has at least one byte.
- res_valid  out  1  result valid; held until res_ready.
- res_ready  in  1  result consumed.
- res_err  out  1  1 = error.
- res_kind  out  3  0 OK, 1 EOF, 2 UNEXPECTED, 3 DEPTH, 4 TRAILING, 5 ESCAPE.
- res_pos  out  POS_W  offending byte index; EOF reports the frame byte count.

Behaviour:
- Reset values: in_ready=1, res_valid=0, res_err=0, res_kind=0, res_pos=0. FSM=VALUE, depth=0, pos=0, error latch clear.
- Whitespace = 0x20, 0x09, 0x0A, 0x0D. Ignored in VALUE, KEY, KEY2, COLON and AFTER.
- States and transitions:
  - VALUE: `{` → push obj, KEY. `[` → push arr, VALUE_OR_CLOSE. `"` → STR. `t`/`f`/`n` → LIT. `-` or digit → NUM. Anything else → UNEXPECTED.
  - VALUE_OR_CLOSE: `]` pops, else behaves as VALUE.
  - KEY: `"` → STR (key flag) or `}` pops. KEY2 (after a comma): `"` only.
  - STR: `\` → ESC. `"` → COLON if key, else AFTER. Bytes < 0x20 → UNEXPECTED.
  - ESC: one of `" \ / b f n r t` → STR. `u` → 4 hex digits, then STR. Any other byte → ESCAPE at that byte.
  - LIT: each byte compared against remaining chars of "true"/"false"/"null". Mismatch → UNEXPECTED. Completion → AFTER.
  - NUM: accepts [0-9 + - . e E] with no further grammar check. Any other byte ends the number and is reclassified in the same cycle as AFTER.
  - COLON: `:` → VALUE.
  - AFTER, depth>0: `,` → KEY2 if top is obj, else VALUE. Matching close pops. Mismatched close → UNEXPECTED.
  - AFTER, depth=0: any non-whitespace → TRAILING.
- Push when depth==MAX_DEPTH → DEPTH error at the opening bracket.
- Stack: MAX_DEPTH-bit register, 1=object, 0=array.
- pos increments on every accepted byte and saturates at all-ones.
- First error is latched with kind and pos. Later bytes are accepted and discarded up to in_last.
- Frame end (in_last accepted):
  - OK if no error latched, depth==0, and state is AFTER or NUM.
  - Otherwise EOF with pos = count, including empty/whitespace-only frames.
- Latency: res_valid asserts the cycle after in_last is accepted.
- in_ready drops the same cycle and stays 0 until the res_valid && res_ready handshake.
- In the handshake cycle, FSM/depth/pos clear and in_ready returns to 1 next cycle. res_* stay stable while res_valid && !res_ready.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro JSON_SCAN_MAX_DEPTH_STAT_EN.
- Defined: adds output res_max_depth [$clog2(MAX_DEPTH+1)-1:0].
  - Records the peak nesting depth reached in the frame, including on error frames (it covers bytes up to the first error).
  - Same timing and stability as res_*; reset value 0.
- Undefined: port and logic absent.

Test Plan:
- `{"a":[1,true]}` then in_last → res_valid next cycle, res_err=0, res_kind=0; with macro, res_max_depth=2.
- `[1,2` → res_kind=1 (EOF), res_pos=4.
- `{"a" 1}` → res_kind=2 (UNEXPECTED), res_pos=5. Follow with `"x\q"` → res_kind=5 (ESCAPE), res_pos=3.
- MAX_DEPTH=16, frame of 17×`[` → res_kind=3 (DEPTH), res_pos=16. All 17 bytes are accepted before the result.
- `1 2` → res_kind=4 (TRAILING), res_pos=2.
  - Hold res_ready=0 for 5 cycles: in_ready=0 and res_* stable throughout.
  - After the handshake, in_ready=1 and the next frame `null` → OK.
- Assert rst_n low mid-frame after `{"a` → all outputs at reset values. Next frame `[]` → OK, res_pos unaffected by the aborted frame.
